// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - start/operand, mthi/mtlo and HI/LO status bundle for md_unit
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hilo_we;
  logic             hilo_sel;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hilo_we, hilo_sel, wdata,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b, hilo_we, hilo_sel, wdata,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle mult/div unit with HI/LO; define MD_UNIT_MADD_EN to enable madd/msub (ops 4-7)
// Combinational core behind a delay counter; HI/LO is written on the edge busy falls.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic     clk,
  input logic     reset,
  md_unit_if.slave md
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
  logic [2:0]         op_q;
  logic               op_legal, accept, done, is_div_q;
  logic               busy_c, res_we, mt_we;

  logic [2*WIDTH-1:0] a_ext, b_ext, prod, hilo, result;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b, uq, ur, quo, rem;

`ifdef MD_UNIT_MADD_EN
  assign op_legal = 1'b1;
`else
  assign op_legal = ~md.op[2];
`endif

  assign is_div_q = (op_q[2:1] == 2'b01);
  assign done     = (state == RUN) && (cnt == CW'(1));
  // The completion cycle may accept the next op so back-to-back issue loses no cycle.
  assign accept   = md.start && op_legal && ((state == IDLE) || done);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (done)   state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state == RUN);
    res_we = done && !(is_div_q && (b_q == '0));
    mt_we  = (state == IDLE) && md.hilo_we && !accept;
  end

  assign hilo = {hi_q, lo_q};

  always_comb begin
    a_ext  = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_ext  = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod   = a_ext * b_ext;
    // Signed divide on magnitudes; most-negative / -1 wraps back to most-negative with rem 0.
    neg_a  = ~op_q[0] & a_q[WIDTH-1];
    neg_b  = ~op_q[0] & b_q[WIDTH-1];
    abs_a  = neg_a ? -a_q : a_q;
    abs_b  = neg_b ? -b_q : b_q;
    uq     = abs_a / abs_b;
    ur     = abs_a % abs_b;
    quo    = (neg_a ^ neg_b) ? -uq : uq;
    rem    = neg_a ? -ur : ur;
    case (op_q)
      3'd0, 3'd1: result = prod;
      3'd2, 3'd3: result = {rem, quo};
      3'd4, 3'd5: result = hilo + prod;
      default:    result = hilo - prod;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (accept) begin
        a_q  <= md.a;
        b_q  <= md.b;
        op_q <= md.op;
        cnt  <= (md.op[2:1] == 2'b01) ? DIV_N : MULT_N;
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
      end
      if (res_we) begin
        {hi_q, lo_q} <= result;
      end else if (mt_we) begin
        if (md.hilo_sel) hi_q <= md.wdata;
        else             lo_q <= md.wdata;
      end
    end
  end

  assign md.busy = busy_c;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
